// File: rtl/sseg_score_display.sv
// rtl/sseg_score_display.sv - double-dabble BCD converter with multiplexed seven-segment scan
module sseg_score_display #(
    parameter int DIGITS         = 4,
    parameter int DATA_W         = 14,
    parameter int CLK_HZ         = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_reset_n,
    input  logic [DATA_W-1:0] data,
    input  logic              load,
    input  logic [DIGITS-1:0] dp_mask,
    output logic [7:0]        sseg_a_to_dp,
    output logic [DIGITS-1:0] sseg_an,
    output logic              busy,
    output logic              overflow
);
    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BCD_W = 4 * DIGITS + 4;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              state;
    logic [DATA_W-1:0]   bin;
    logic [BCD_W-1:0]    bcd;
    logic [BCD_W-1:0]    bcd_adj;
    logic                lost;
    logic [CNT_W-1:0]    cnt;
    logic                pend;
    logic [DATA_W-1:0]   pend_data;
    logic [4*DIGITS-1:0] disp;
    logic [PRE_W-1:0]    pre;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          nib;
    logic                blank;
    logic                dp;
    logic [6:0]          glyph;
    logic [6:0]          dec;
    logic [DIGITS-1:0]   onehot;

    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < DIGITS + 1; n++) begin
            if (bcd[4*n +: 4] >= 4'd5)
                bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            disp      <= '0;
            pend      <= 1'b0;
            pend_data <= '0;
            bin       <= '0;
            bcd       <= '0;
            lost      <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin   <= data;
                        bcd   <= '0;
                        lost  <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (load) begin
                        pend      <= 1'b1;
                        pend_data <= data;
                    end
                    // Anything pushed past the guard nibble means the value cannot fit.
                    lost <= lost | bcd_adj[BCD_W-1];
                    bcd  <= {bcd_adj[BCD_W-2:0], bin[DATA_W-1]};
                    bin  <= bin << 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    if (lost || (bcd[BCD_W-1 -: 4] != 4'd0)) begin
                        overflow <= 1'b1;
                    end else begin
                        overflow <= 1'b0;
                        disp     <= bcd[4*DIGITS-1:0];
                    end
                    // A load arriving on this very cycle is newer than the pending one.
                    if (load || pend) begin
                        bin   <= load ? data : pend_data;
                        bcd   <= '0;
                        lost  <= 1'b0;
                        cnt   <= '0;
                        pend  <= 1'b0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        nib    = 4'd0;
        blank  = 1'b0;
        dp     = 1'b0;
        onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx) begin
                nib       = disp[4*i +: 4];
                blank     = BLANK_LZ && (i > 0) && ((disp >> (4 * i)) == '0);
                dp        = dp_mask[i];
                onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        case (nib)
            4'd0:    dec = 7'b0111111;
            4'd1:    dec = 7'b0000110;
            4'd2:    dec = 7'b1011011;
            4'd3:    dec = 7'b1001111;
            4'd4:    dec = 7'b1100110;
            4'd5:    dec = 7'b1101101;
            4'd6:    dec = 7'b1111101;
            4'd7:    dec = 7'b0000111;
            4'd8:    dec = 7'b1111111;
            4'd9:    dec = 7'b1101111;
            default: dec = 7'b0000000;
        endcase
        if (overflow)
            glyph = 7'b1000000;
        else if (blank)
            glyph = 7'b0000000;
        else
            glyph = dec;
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            pre          <= '0;
            idx          <= '0;
            sseg_a_to_dp <= SEG_OFF;
            sseg_an      <= AN_OFF;
        end else begin
            if (pre == PRE_W'(DIV - 1)) begin
                pre <= '0;
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
            sseg_a_to_dp <= SEG_ACTIVE_LOW ? ~{dp, glyph} : {dp, glyph};
            sseg_an      <= AN_ACTIVE_LOW ? ~onehot : onehot;
        end
    end
endmodule
